// File: rtl/sdram_page_sched.sv
// sdram_page_sched: shares one full-page SDRAM controller among NCH host
// pipe channels. Each channel owns a ring of DEPTH pages in SDRAM. Page
// writes drain a channel's write FIFO and page reads refill its read FIFO.
// Channels are served round-robin, and only one page command is in flight.
module sdram_page_sched #(
    parameter int NCH         = 2,
    parameter int CH_W        = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int CNT_W       = 10,
    parameter int PAGE_WORDS  = 512,
    parameter int PAGE_ADDR_W = 15,
    parameter int LP          = PAGE_ADDR_W - $clog2(NCH)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NCH-1:0]          i_en_read,
    input  logic [NCH-1:0]          i_en_write,
    input  logic [NCH*CNT_W-1:0]    i_wr_fifo_count,
    input  logic [NCH*CNT_W-1:0]    i_rd_fifo_free,
    output logic                    o_cmd_valid,
    input  logic                    i_cmd_ready,
    output logic                    o_cmd_write,
    output logic [CH_W-1:0]         o_cmd_chan,
    output logic [PAGE_ADDR_W-1:0]  o_cmd_page,
    input  logic                    i_cmd_done,
    output logic [NCH*(LP+1)-1:0]   o_pages_stored,
    output logic [NCH-1:0]          o_ch_full,
    output logic [NCH-1:0]          o_ch_empty,
    output logic                    o_busy
);

    localparam int          DEPTH    = 1 << LP;
    localparam logic [LP:0] FULL_CNT = (LP+1)'(DEPTH);
    localparam logic [31:0] PW       = 32'(PAGE_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BUSY,
        ST_SETTLE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    // Registered command fields and arbitration history
    logic                    r_cmd_write;
    logic [CH_W-1:0]         r_cmd_chan;
    logic [PAGE_ADDR_W-1:0]  r_cmd_page;
    logic [CH_W-1:0]         r_last_grant;

    // Per-channel state, gathered from the generate blocks below
    logic [LP-1:0]           w_wr_ptr   [NCH];
    logic [LP-1:0]           w_rd_ptr   [NCH];
    logic [LP:0]             w_stored   [NCH];
    logic [NCH-1:0]          w_last_op;
    logic [NCH-1:0]          w_we;
    logic [NCH-1:0]          w_re;
    logic [NCH-1:0]          w_elig;
    logic [NCH-1:0]          w_full;
    logic [NCH-1:0]          w_empty;

    // Arbitration results
    logic                    w_found;
    logic [CH_W-1:0]         w_pick;
    logic [CH_W-1:0]         w_rr_idx;
    logic                    w_op_write;
    logic [LP-1:0]           w_local_ptr;
    logic [PAGE_ADDR_W-1:0]  w_page;
    logic                    w_done_hit;

    // The controller reports completion only while a command is outstanding
    assign w_done_hit = (r_state == ST_BUSY) && i_cmd_done;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [CNT_W-1:0] w_wcnt;
            logic [CNT_W-1:0] w_rfree;
            logic             w_mine;
            logic [LP-1:0]    r_wr_ptr;
            logic [LP-1:0]    r_rd_ptr;
            logic [LP:0]      r_stored;
            logic             r_last_op;

            assign w_wcnt  = i_wr_fifo_count[gi*CNT_W +: CNT_W];
            assign w_rfree = i_rd_fifo_free[gi*CNT_W +: CNT_W];
            assign w_mine  = w_done_hit && (r_cmd_chan == CH_W'(gi));

            assign w_full[gi]  = (r_stored == FULL_CNT);
            assign w_empty[gi] = (r_stored == '0);
            // A full page must fit on both sides before a transfer is offered
            assign w_we[gi]    = i_en_write[gi] & (32'(w_wcnt) >= PW) & ~w_full[gi];
            assign w_re[gi]    = i_en_read[gi] & (32'(w_rfree) >= PW) & ~w_empty[gi];
            assign w_elig[gi]  = w_we[gi] | w_re[gi];

            assign w_wr_ptr[gi]  = r_wr_ptr;
            assign w_rd_ptr[gi]  = r_rd_ptr;
            assign w_stored[gi]  = r_stored;
            assign w_last_op[gi] = r_last_op;

            assign o_pages_stored[gi*(LP+1) +: (LP+1)] = r_stored;

            // Ring pointers and stored-page count advance when this channel's page completes
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_wr_ptr  <= '0;
                    r_rd_ptr  <= '0;
                    r_stored  <= '0;
                    r_last_op <= 1'b0;
                end else if (w_mine) begin
                    r_last_op <= r_cmd_write;
                    if (r_cmd_write) begin
                        r_wr_ptr <= r_wr_ptr + LP'(1);
                        r_stored <= r_stored + (LP+1)'(1);
                    end else begin
                        r_rd_ptr <= r_rd_ptr + LP'(1);
                        r_stored <= r_stored - (LP+1)'(1);
                    end
                end
            end
        end
    endgenerate

    // Round-robin search: first eligible channel after the last grant
    always_comb begin
        w_found  = 1'b0;
        w_pick   = '0;
        w_rr_idx = '0;
        for (int k = 1; k <= NCH; k++) begin
            w_rr_idx = CH_W'((int'(r_last_grant) + k) % NCH);
            if (!w_found && w_elig[w_rr_idx]) begin
                w_found = 1'b1;
                w_pick  = w_rr_idx;
            end
        end
    end

    // Op choice for the winner: a tie flips relative to that channel's last completed op
    always_comb begin
        w_op_write  = 1'b0;
        w_local_ptr = '0;
        if (w_we[w_pick] && w_re[w_pick]) begin
            w_op_write = ~w_last_op[w_pick];
        end else begin
            w_op_write = w_we[w_pick];
        end
        w_local_ptr = w_op_write ? w_wr_ptr[w_pick] : w_rd_ptr[w_pick];
    end

    generate
        if (NCH == 1) begin : g_page_single
            assign w_page = w_local_ptr;
        end else begin : g_page_multi
            assign w_page = {w_pick, w_local_ptr};
        end
    endgenerate

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_found)     w_state_next = ST_ISSUE;
            ST_ISSUE:  if (i_cmd_ready) w_state_next = ST_BUSY;
            ST_BUSY:   if (i_cmd_done)  w_state_next = ST_SETTLE;
            ST_SETTLE:                  w_state_next = ST_IDLE;
            default:                    w_state_next = ST_IDLE;
        endcase
    end

    // Latch the command in IDLE so it stays stable through ISSUE; record the grant on accept
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cmd_write  <= 1'b0;
            r_cmd_chan   <= '0;
            r_cmd_page   <= '0;
            r_last_grant <= CH_W'(NCH - 1);
        end else begin
            if (r_state == ST_IDLE && w_found) begin
                r_cmd_write <= w_op_write;
                r_cmd_chan  <= w_pick;
                r_cmd_page  <= w_page;
            end
            if (r_state == ST_ISSUE && i_cmd_ready) begin
                r_last_grant <= r_cmd_chan;
            end
        end
    end

    assign o_cmd_valid = (r_state == ST_ISSUE);
    assign o_busy      = (r_state != ST_IDLE);
    assign o_cmd_write = r_cmd_write;
    assign o_cmd_chan  = r_cmd_chan;
    assign o_cmd_page  = r_cmd_page;
    assign o_ch_full   = w_full;
    assign o_ch_empty  = w_empty;

endmodule

// File: tb/tb_sdram_page_sched.sv
// Testbench for sdram_page_sched: two channels, eight pages per channel.
// A small reference model holds per-channel ring pointers, stored counts and
// the round-robin/op history. It predicts each command from the channel rules.
module tb_sdram_page_sched;

    localparam int NCH         = 2;
    localparam int CH_W        = 1;
    localparam int CNT_W       = 10;
    localparam int PAGE_WORDS  = 512;
    localparam int PAGE_ADDR_W = 4;
    localparam int LP          = 3;
    localparam int DEPTH       = 8;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NCH-1:0]          en_read;
    logic [NCH-1:0]          en_write;
    logic [NCH*CNT_W-1:0]    wr_cnt_v;
    logic [NCH*CNT_W-1:0]    rd_free_v;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_write;
    logic [CH_W-1:0]         cmd_chan;
    logic [PAGE_ADDR_W-1:0]  cmd_page;
    logic                    cmd_done;
    logic [NCH*(LP+1)-1:0]   pages_stored;
    logic [NCH-1:0]          ch_full;
    logic [NCH-1:0]          ch_empty;
    logic                    busy;

    always #5 clk = ~clk;

    sdram_page_sched #(
        .NCH(NCH), .CNT_W(CNT_W), .PAGE_WORDS(PAGE_WORDS), .PAGE_ADDR_W(PAGE_ADDR_W)
    ) dut (
        .i_clk(clk), .i_reset(reset),
        .i_en_read(en_read), .i_en_write(en_write),
        .i_wr_fifo_count(wr_cnt_v), .i_rd_fifo_free(rd_free_v),
        .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready),
        .o_cmd_write(cmd_write), .o_cmd_chan(cmd_chan), .o_cmd_page(cmd_page),
        .i_cmd_done(cmd_done), .o_pages_stored(pages_stored),
        .o_ch_full(ch_full), .o_ch_empty(ch_empty), .o_busy(busy)
    );

    // Stimulus levels and reference model state
    int wcnt [NCH];
    int rfree[NCH];
    int m_stored[NCH];
    int m_wp[NCH];
    int m_rp[NCH];
    bit m_last_op[NCH];
    int m_last_grant;
    int n_total = 0;
    int n_pass  = 0;
    int lat;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic apply();
        for (int c = 0; c < NCH; c++) begin
            wr_cnt_v[c*CNT_W +: CNT_W]  = CNT_W'(wcnt[c]);
            rd_free_v[c*CNT_W +: CNT_W] = CNT_W'(rfree[c]);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_stored[c]  = 0;
            m_wp[c]      = 0;
            m_rp[c]      = 0;
            m_last_op[c] = 1'b0;
        end
        m_last_grant = NCH - 1;
    endtask

    // Next command from the channel rules: scan channels starting after the last grant
    function automatic void predict(output bit has, output bit w, output int ch, output int pg);
        bit we;
        bit re;
        int c;
        has = 1'b0; w = 1'b0; ch = 0; pg = 0;
        for (int k = 1; k <= NCH; k++) begin
            c  = (m_last_grant + k) % NCH;
            we = en_write[c] && (wcnt[c] >= PAGE_WORDS) && (m_stored[c] < DEPTH);
            re = en_read[c] && (rfree[c] >= PAGE_WORDS) && (m_stored[c] > 0);
            if (!has && (we || re)) begin
                has = 1'b1;
                ch  = c;
                w   = (we && re) ? !m_last_op[c] : we;
                pg  = c * DEPTH + (w ? m_wp[c] : m_rp[c]);
            end
        end
    endfunction

    // One full page transaction: wait, compare fields, optional stall/spurious done, accept, complete
    task automatic xfer(input int rdly, input int ddly, input bit spur, output int latency);
        bit has;
        bit hw;
        int hc;
        int hp;
        int n;
        predict(has, hw, hc, hp);
        n = 0;
        while (cmd_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        latency = n;
        chk("cmd_valid_seen", cmd_valid, 1);
        if (cmd_valid !== 1'b1) return;
        chk("cmd_write", cmd_write, hw);
        chk("cmd_chan", cmd_chan, hc);
        chk("cmd_page", cmd_page, hp);
        if (spur) begin
            cmd_done = 1'b1;
            step();
            cmd_done = 1'b0;
            chk("spur_valid", cmd_valid, 1);
            chk("spur_stored", pages_stored[hc*(LP+1) +: (LP+1)], m_stored[hc]);
        end
        for (int i = 0; i < rdly; i++) begin
            step();
            chk("hold_valid", cmd_valid, 1);
            chk("hold_fields", {cmd_write, cmd_chan, cmd_page}, {hw, 1'(hc), 4'(hp)});
        end
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        m_last_grant = hc;
        chk("busy_after_accept", busy, 1);
        chk("valid_after_accept", cmd_valid, 0);
        for (int i = 0; i < ddly; i++) step();
        cmd_done = 1'b1;
        step();
        cmd_done = 1'b0;
        if (hw) begin
            m_stored[hc]++;
            m_wp[hc] = (m_wp[hc] + 1) % DEPTH;
        end else begin
            m_stored[hc]--;
            m_rp[hc] = (m_rp[hc] + 1) % DEPTH;
        end
        m_last_op[hc] = hw;
        chk("pages_stored", pages_stored[hc*(LP+1) +: (LP+1)], m_stored[hc]);
        chk("ch_full", ch_full[hc], m_stored[hc] == DEPTH);
        chk("ch_empty", ch_empty[hc], m_stored[hc] == 0);
        $display("xfer %s chan=%0d page=%0h stored=%0d", hw ? "W" : "R", hc, hp, m_stored[hc]);
    endtask

    task automatic expect_none(input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (cmd_valid !== 1'b0) seen = 1'b1;
        end
        chk("no_cmd", seen, 0);
        $display("idle %0d cycles, no command expected", cycles);
    endtask

    task automatic run_one(input int rdly, input int ddly, input bit spur);
        bit has;
        bit hw;
        int hc;
        int hp;
        int l;
        predict(has, hw, hc, hp);
        if (has) xfer(rdly, ddly, spur, l);
        else expect_none(4);
    endtask

    initial begin
        reset = 1'b1; en_read = '0; en_write = '0; cmd_ready = 1'b0; cmd_done = 1'b0;
        for (int c = 0; c < NCH; c++) begin wcnt[c] = 0; rfree[c] = 0; end
        apply();
        step();
        step();
        reset = 1'b0;
        model_reset();

        // Reset values
        chk("rst_valid", cmd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_write", cmd_write, 0);
        chk("rst_chan", cmd_chan, 0);
        chk("rst_page", cmd_page, 0);
        chk("rst_stored", pages_stored, 0);
        chk("rst_empty", ch_empty, 2'b11);
        chk("rst_full", ch_full, 2'b00);

        // Threshold: 511 words is not a page, 512 is
        en_write = 2'b01; wcnt[0] = 511; apply();
        expect_none(5);
        wcnt[0] = 512; apply();
        xfer(0, 3, 1'b0, lat);
        chk("first_latency", lat, 1);
        chk("first_stored0", pages_stored[3:0], 1);

        // Both channels writing: grants alternate; done -> next valid spacing
        en_write = 2'b11; wcnt[0] = 600; wcnt[1] = 600; apply();
        xfer(0, 5, 1'b0, lat);
        chk("done_to_valid", lat, 2);
        for (int i = 0; i < 3; i++) xfer(0, 5, 1'b0, lat);

        // Fill channel 0, then no further write even with a full FIFO
        en_write = 2'b01; wcnt[0] = 1023; wcnt[1] = 0; apply();
        for (int i = 0; i < DEPTH && m_stored[0] < DEPTH; i++) xfer(0, 2, 1'b0, lat);
        chk("full_ch0", ch_full[0], 1);
        expect_none(10);
        en_write = 2'b00; en_read = 2'b01; rfree[0] = 512; apply();
        xfer(0, 2, 1'b0, lat);
        chk("after_read_stored0", pages_stored[3:0], 7);

        // Tie on channel 0: ops alternate and pointers wrap
        en_write = 2'b01; apply();
        for (int i = 0; i < 8; i++) run_one(0, 1, 1'b0);

        // Controller stall in ISSUE with a spurious done
        xfer(10, 2, 1'b1, lat);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            en_write = 2'($urandom);
            en_read  = 2'($urandom);
            for (int c = 0; c < NCH; c++) begin
                wcnt[c]  = int'($urandom_range(440, 1023));
                rfree[c] = int'($urandom_range(440, 1023));
            end
            apply();
            run_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), 1'($urandom));
        end

        // Reset while BUSY abandons the command
        en_write = 2'b11; en_read = 2'b11;
        for (int c = 0; c < NCH; c++) begin wcnt[c] = 1023; rfree[c] = 1023; end
        apply();
        for (int i = 0; i < 20 && cmd_valid !== 1'b1; i++) step();
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        step();
        chk("busy_before_reset", busy, 1);
        reset = 1'b1; en_write = '0; en_read = '0;
        step();
        reset = 1'b0;
        model_reset();
        chk("rst2_busy", busy, 0);
        chk("rst2_valid", cmd_valid, 0);
        chk("rst2_cmd", {cmd_write, cmd_chan, cmd_page}, 0);
        chk("rst2_stored", pages_stored, 0);
        chk("rst2_empty", ch_empty, 2'b11);
        chk("rst2_full", ch_full, 2'b00);
        $display("reset during BUSY applied");

        // After reset channel 0 has first priority again, page 0
        en_write = 2'b11; apply();
        xfer(0, 1, 1'b0, lat);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
